// File: rtl/m68k_bus_arbiter.sv
// m68k_bus_arbiter: hands the 68000 bus to one of BW external masters using the BR/BG/BGACK handshake.
// Define M68K_ARB_RR_EN for round-robin priority; otherwise the lowest requesting index wins.
module m68k_bus_arbiter #(
    parameter int BW = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cen,
    input  logic [BW-1:0] dev_br,
    input  logic          cpu_BGn,
    input  logic          cpu_ASn,
    input  logic          cpu_DTACKn,
    output logic          cpu_BRn,
    output logic          cpu_BGACKn,
    output logic [BW-1:0] dev_bg
);
    localparam int OW = (BW > 1) ? $clog2(BW) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_OWN  = 2'd2
    } state_t;

    state_t        state_q;
    logic [OW-1:0] owner_q;
    logic [OW-1:0] winner_d;
    logic [OW-1:0] win_off_s;
    logic          br_n_q;
    logic          bgack_n_q;
    logic [BW-1:0] bg_q;
    logic [BW-1:0] br_rot_s;
    logic          bus_free_s;
    logic          owner_req_s;

    // Grant only once the CPU has released the bus and its last cycle is fully over.
    assign bus_free_s  = ~cpu_BGn & cpu_ASn & cpu_DTACKn;
    assign owner_req_s = dev_br[owner_q];

    // Position of the first requester in the (possibly rotated) request vector.
    always_comb begin
        win_off_s = '0;
        for (int k = BW - 1; k >= 0; k--) begin
            if (br_rot_s[k]) begin
                win_off_s = OW'(k);
            end else begin
                win_off_s = win_off_s;
            end
        end
    end

`ifdef M68K_ARB_RR_EN
    logic [OW-1:0]   rr_ptr_q;
    logic [OW-1:0]   rr_ptr_d;
    logic [2*BW-1:0] br_dbl_s;

    assign br_dbl_s = {dev_br, dev_br} >> rr_ptr_q;
    assign br_rot_s = br_dbl_s[BW-1:0];

    // Undo the rotation for the winner and compute the pointer that follows the owner.
    always_comb begin
        int sum_v;
        int nxt_v;
        sum_v = int'(win_off_s) + int'(rr_ptr_q);
        nxt_v = int'(owner_q) + 1;
        if (sum_v >= BW) begin
            winner_d = OW'(sum_v - BW);
        end else begin
            winner_d = OW'(sum_v);
        end
        if (nxt_v >= BW) begin
            rr_ptr_d = '0;
        end else begin
            rr_ptr_d = OW'(nxt_v);
        end
    end

    // Round-robin pointer moves past the owner the moment it takes the bus.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q <= '0;
        end else if (cen && (state_q == ST_REQ) && owner_req_s && bus_free_s) begin
            rr_ptr_q <= rr_ptr_d;
        end else begin
            rr_ptr_q <= rr_ptr_q;
        end
    end
`else
    assign br_rot_s = dev_br;
    assign winner_d = win_off_s;
`endif

    // Arbitration FSM with registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            owner_q   <= '0;
            br_n_q    <= 1'b1;
            bgack_n_q <= 1'b1;
            bg_q      <= '0;
        end else if (cen) begin
            case (state_q)
                ST_IDLE: begin
                    if (|dev_br) begin
                        owner_q <= winner_d;
                        br_n_q  <= 1'b0;
                        state_q <= ST_REQ;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_REQ: begin
                    // A withdrawn request wins over a simultaneous grant.
                    if (!owner_req_s) begin
                        br_n_q  <= 1'b1;
                        state_q <= ST_IDLE;
                    end else if (bus_free_s) begin
                        br_n_q    <= 1'b1;
                        bgack_n_q <= 1'b0;
                        bg_q      <= BW'(1'b1) << owner_q;
                        state_q   <= ST_OWN;
                    end else begin
                        state_q <= ST_REQ;
                    end
                end
                ST_OWN: begin
                    if (!owner_req_s) begin
                        bgack_n_q <= 1'b1;
                        bg_q      <= '0;
                        state_q   <= ST_IDLE;
                    end else begin
                        state_q <= ST_OWN;
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    owner_q   <= '0;
                    br_n_q    <= 1'b1;
                    bgack_n_q <= 1'b1;
                    bg_q      <= '0;
                end
            endcase
        end else begin
            state_q <= state_q;
        end
    end

    assign cpu_BRn    = br_n_q;
    assign cpu_BGACKn = bgack_n_q;
    assign dev_bg     = bg_q;

endmodule

// File: tb/tb_m68k_bus_arbiter.sv
// Self-checking bench for m68k_bus_arbiter: directed handshake scenarios plus randomized traffic
// compared every cycle against a transaction-level model of the arbitration rules.
module tb_m68k_bus_arbiter;
    localparam int BW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          cen;
    logic [BW-1:0] dev_br;
    logic          cpu_BGn;
    logic          cpu_ASn;
    logic          cpu_DTACKn;
    logic          cpu_BRn;
    logic          cpu_BGACKn;
    logic [BW-1:0] dev_bg;

    int checks = 0;
    int errors = 0;

    m68k_bus_arbiter #(.BW(BW)) dut (
        .clk        (clk),
        .rst        (rst),
        .cen        (cen),
        .dev_br     (dev_br),
        .cpu_BGn    (cpu_BGn),
        .cpu_ASn    (cpu_ASn),
        .cpu_DTACKn (cpu_DTACKn),
        .cpu_BRn    (cpu_BRn),
        .cpu_BGACKn (cpu_BGACKn),
        .dev_bg     (dev_bg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: who is requesting the bus, who owns it, where the search starts.
    bit m_req   = 1'b0;
    bit m_own   = 1'b0;
    int m_owner = 0;
    int m_start = 0;

    function automatic int pick(input logic [BW-1:0] br, input int start);
        for (int k = 0; k < BW; k++) begin
            int i;
            i = (start + k) % BW;
            if (br[i]) return i;
        end
        return 0;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_req = 1'b0; m_own = 1'b0; m_owner = 0; m_start = 0;
        end else if (cen) begin
            if (!m_req && !m_own) begin
                if (dev_br != '0) begin
                    m_owner = pick(dev_br, m_start);
                    m_req   = 1'b1;
                end
            end else if (m_req) begin
                if (!dev_br[m_owner]) begin
                    m_req = 1'b0;
                end else if (!cpu_BGn && cpu_ASn && cpu_DTACKn) begin
                    m_req = 1'b0;
                    m_own = 1'b1;
`ifdef M68K_ARB_RR_EN
                    m_start = (m_owner + 1) % BW;
`endif
                end
            end else if (!dev_br[m_owner]) begin
                m_own = 1'b0;
            end
        end
    end

    // Every-cycle comparison of DUT outputs against the model.
    always @(negedge clk) begin
        chk("model_BRn", 32'(cpu_BRn), 32'(!m_req));
        chk("model_BGACKn", 32'(cpu_BGACKn), 32'(!m_own));
        chk("model_bg", 32'(dev_bg), m_own ? (32'd1 << m_owner) : 32'd0);
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_out(input string name, input logic brn, input logic bgackn, input logic [BW-1:0] bg);
        chk({name, "_BRn"}, 32'(cpu_BRn), 32'(brn));
        chk({name, "_BGACKn"}, 32'(cpu_BGACKn), 32'(bgackn));
        chk({name, "_bg"}, 32'(dev_bg), 32'(bg));
    endtask

    initial begin
        logic [BW-1:0] flip;
        rst = 1'b1; cen = 1'b1; dev_br = 3'b001;
        cpu_BGn = 1'b1; cpu_ASn = 1'b1; cpu_DTACKn = 1'b1;

        // Reset held with a pending request.
        repeat (2) begin
            tick();
            chk_out("reset", 1'b1, 1'b1, 3'b000);
        end
        rst = 1'b0;
        tick();
        chk_out("post_reset_req", 1'b0, 1'b1, 3'b000);

        // Grant blocked while the CPU cycle is still running.
        cpu_BGn = 1'b0; cpu_ASn = 1'b0;
        repeat (4) begin
            tick();
            chk_out("as_busy", 1'b0, 1'b1, 3'b000);
        end
        cpu_ASn = 1'b1;
        tick();
        chk_out("grant0", 1'b1, 1'b0, 3'b001);
        cpu_BGn = 1'b1;
        tick();
        chk_out("own0_hold", 1'b1, 1'b0, 3'b001);
        dev_br = 3'b000;
        tick();
        chk_out("release0", 1'b1, 1'b1, 3'b000);

        // Request withdrawn before the CPU grants.
        dev_br = 3'b001;
        tick();
        chk_out("wd_req", 1'b0, 1'b1, 3'b000);
        dev_br = 3'b000;
        tick();
        chk_out("wd_drop", 1'b1, 1'b1, 3'b000);
        tick();
        chk_out("wd_idle", 1'b1, 1'b1, 3'b000);

        // Priority between simultaneous requests.
        rst = 1'b1; tick(); rst = 1'b0;
        dev_br = 3'b011;
        tick();
        chk_out("pri_req", 1'b0, 1'b1, 3'b000);
        cpu_BGn = 1'b0;
        tick();
        chk_out("pri_grant0", 1'b1, 1'b0, 3'b001);
        cpu_BGn = 1'b1; dev_br = 3'b010;
        tick();
        chk_out("pri_rel0", 1'b1, 1'b1, 3'b000);
        tick();
        chk_out("pri_req1", 1'b0, 1'b1, 3'b000);
        cpu_BGn = 1'b0;
        tick();
        chk_out("pri_grant1", 1'b1, 1'b0, 3'b010);
        cpu_BGn = 1'b1; dev_br = 3'b000;
        tick();
        dev_br = 3'b111;
        tick();
        cpu_BGn = 1'b0;
        tick();
`ifdef M68K_ARB_RR_EN
        chk_out("pri_all", 1'b1, 1'b0, 3'b100);
`else
        chk_out("pri_all", 1'b1, 1'b0, 3'b001);
`endif
        cpu_BGn = 1'b1; dev_br = 3'b000;
        tick();

        // Clock-enable gating holds everything while the grant conditions are met.
        dev_br = 3'b001;
        tick();
        cen = 1'b0; cpu_BGn = 1'b0; cpu_ASn = 1'b1; cpu_DTACKn = 1'b1;
        repeat (10) begin
            tick();
            chk_out("cen_hold", 1'b0, 1'b1, 3'b000);
        end
        cen = 1'b1;
        tick();
        chk_out("cen_grant", 1'b1, 1'b0, 3'b001);
        cpu_BGn = 1'b1; dev_br = 3'b000;
        tick();

        // Randomized traffic against the model.
        for (int n = 0; n < 4000; n++) begin
            rst        = ($urandom_range(0, 299) == 0);
            cen        = ($urandom_range(0, 3) != 0);
            flip       = '0;
            for (int k = 0; k < BW; k++) flip[k] = ($urandom_range(0, 9) == 0);
            dev_br     = dev_br ^ flip;
            cpu_BGn    = 1'($urandom_range(0, 1));
            cpu_ASn    = 1'($urandom_range(0, 1));
            cpu_DTACKn = 1'($urandom_range(0, 1));
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
